// File: rtl/multichannel_moving_average_if.sv
// -----------------------------------------------------------------------------
// multichannel_moving_average_if
//   Sample/result bus between the ADC front end and the moving-average filter.
//
//   Signals
//     clear       flush of every channel's history (source -> filter)
//     in_valid    a sample is presented this cycle
//     in_ch       channel index of the sample
//     in_data     unsigned sample value
//     out_valid   out_* carry a result this cycle
//     out_ch      channel of the result
//     out_data    window mean
//     out_primed  the window was full of real samples for this result
//
//   Modports
//     master  sample source / result consumer (testbench, ADC front end)
//     slave   the filter itself
// -----------------------------------------------------------------------------
interface multichannel_moving_average_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic              clear;
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_primed;

    modport master (
        output clear, in_valid, in_ch, in_data,
        input  out_valid, out_ch, out_data, out_primed
    );

    modport slave (
        input  clear, in_valid, in_ch, in_data,
        output out_valid, out_ch, out_data, out_primed
    );
endinterface

// File: rtl/multichannel_moving_average.sv
// -----------------------------------------------------------------------------
// multichannel_moving_average
//   N-channel, 2**LOG2_DEPTH-sample moving-average filter for the relay current
//   path. Time-multiplexed ADC samples arrive one channel per cycle; each
//   channel owns a circular history buffer, a running sum and a fill count.
//   The window mean of an accepted sample appears one cycle later.
//
//   Parameters
//     DATA_W      sample / output width (unsigned)
//     LOG2_DEPTH  window = 2**LOG2_DEPTH samples, 1..6
//     NUM_CH      number of independent channels, 1..8
//
//   Ports
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    multichannel_moving_average_if.slave (clear, in_*, out_*)
//
//   Build option
//     MAF_ROUND_EN  defined: mean rounds half up; undefined: mean truncates.
// -----------------------------------------------------------------------------
module multichannel_moving_average #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 2,
    parameter int NUM_CH     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    multichannel_moving_average_if.slave  bus
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;

    localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);

    // Per-channel state.
    logic [DATA_W-1:0]     hist [NUM_CH][DEPTH];
    logic [SUM_W-1:0]      sum  [NUM_CH];
    logic [LOG2_DEPTH-1:0] ptr  [NUM_CH];
    logic [LOG2_DEPTH:0]   fill [NUM_CH];

    // Datapath for the sample presented this cycle.
    logic                  ch_ok;
    logic                  accept;
    logic [CH_W-1:0]       ch_sel;
    logic [DATA_W-1:0]     oldest;
    logic [SUM_W:0]        sum_wide;
    logic [SUM_W-1:0]      sum_new;
    logic [LOG2_DEPTH:0]   fill_new;
    logic [DATA_W-1:0]     mean;

    // NOTE: every signal written here gets an unconditional value first, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        ch_ok    = int'(bus.in_ch) < NUM_CH;
        accept   = bus.in_valid && !bus.clear && ch_ok;
        // An out-of-range index is never accepted; steering it to channel 0
        // only keeps the array read in bounds.
        ch_sel   = ch_ok ? bus.in_ch : '0;
        oldest   = hist[ch_sel][ptr[ch_sel]];

        // Add then subtract in SUM_W+1 bits. The running sum always includes
        // the oldest sample, so the result is never negative and fits SUM_W.
        sum_wide = {1'b0, sum[ch_sel]}
                 + {{(LOG2_DEPTH+1){1'b0}}, bus.in_data}
                 - {{(LOG2_DEPTH+1){1'b0}}, oldest};
        sum_new  = SUM_W'(sum_wide);

        fill_new = (fill[ch_sel] == FILL_FULL) ? FILL_FULL : fill[ch_sel] + 1'b1;

`ifdef MAF_ROUND_EN
        // Round half up. Largest sum plus half an LSB still shifts down to at
        // most 2**DATA_W-1, so the cast drops only zero bits.
        mean = DATA_W'(({1'b0, sum_new} + (SUM_W+1)'(DEPTH / 2)) >> LOG2_DEPTH);
`else
        mean = DATA_W'(sum_new >> LOG2_DEPTH);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this edge sees the pre-edge value regardless of statement order.
    // NOTE: the history buffers are cleared on reset and on clear because an
    // unfilled slot must read as 0 in the running sum; this is deliberate.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    hist[c][d] <= '0;
                end
                sum[c]  <= '0;
                ptr[c]  <= '0;
                fill[c] <= '0;
            end
        end else if (accept) begin
            // Overwrite the oldest slot; the pointer wraps naturally.
            hist[ch_sel][ptr[ch_sel]] <= bus.in_data;
            sum[ch_sel]               <= sum_new;
            ptr[ch_sel]               <= ptr[ch_sel] + 1'b1;
            fill[ch_sel]              <= fill_new;
        end
    end

    // Result register: out_ch/out_data hold between results; clear drops only
    // the primed flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_data   <= '0;
            bus.out_primed <= 1'b0;
        end else begin
            bus.out_valid <= accept;
            if (bus.clear) begin
                bus.out_primed <= 1'b0;
            end else if (accept) begin
                bus.out_ch     <= bus.in_ch;
                bus.out_data   <= mean;
                bus.out_primed <= (fill_new == FILL_FULL);
            end
        end
    end

endmodule

// File: tb/tb_multichannel_moving_average.sv
// -----------------------------------------------------------------------------
// tb_multichannel_moving_average
//   Self-checking bench for multichannel_moving_average (DEPTH=4, NUM_CH=3,
//   DATA_W=16). Expected results come from a window model that re-sums the
//   stored history; they are queued when a sample is driven and popped when
//   the filter reports a result. Define MAF_ROUND_EN to check the rounding
//   build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multichannel_moving_average;

    localparam int DATA_W = 16;
    localparam int LOG2_D = 2;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    multichannel_moving_average_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    multichannel_moving_average #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_D),
        .NUM_CH     (NUM_CH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned ch;
        int unsigned data;
        int unsigned primed;
    } exp_t;

    exp_t sb[$];

    // Window model.
    int unsigned m_hist [NUM_CH][DEPTH];
    int          m_ptr  [NUM_CH];
    int          m_fill [NUM_CH];
    int unsigned last_ch, last_data, last_primed;

    // Most recent values seen on the result bus.
    int unsigned obs_data, obs_primed, obs_ch, obs_valid;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_zero(input bit keep_out);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = 0; d < DEPTH; d++) m_hist[c][d] = 0;
            m_ptr[c]  = 0;
            m_fill[c] = 0;
        end
        if (!keep_out) begin
            last_ch   = 0;
            last_data = 0;
        end
        last_primed = 0;
    endtask

    // One clock: drive inputs, update model, then check the result bus.
    task automatic step(input bit v, input int ch, input int unsigned d,
                        input bit clr, input bit rst);
        bit          exp_v;
        int unsigned s;
        exp_t        e;
        exp_v         = 1'b0;
        reset         = rst;
        bus.clear     = clr;
        bus.in_valid  = v;
        bus.in_ch     = ch[CH_W-1:0];
        bus.in_data   = d[DATA_W-1:0];

        if (rst) begin
            model_zero(1'b0);
            sb.delete();
        end else if (clr) begin
            model_zero(1'b1);
        end else if (v && ch < NUM_CH) begin
            m_hist[ch][m_ptr[ch]] = d;
            m_ptr[ch]  = (m_ptr[ch] + 1) % DEPTH;
            m_fill[ch] = (m_fill[ch] < DEPTH) ? m_fill[ch] + 1 : DEPTH;
            s = 0;
            for (int k = 0; k < DEPTH; k++) s += m_hist[ch][k];
`ifdef MAF_ROUND_EN
            e.data = (s + DEPTH / 2) / DEPTH;
`else
            e.data = s / DEPTH;
`endif
            e.ch     = ch;
            e.primed = (m_fill[ch] == DEPTH);
            sb.push_back(e);
            last_ch     = e.ch;
            last_data   = e.data;
            last_primed = e.primed;
            exp_v       = 1'b1;
        end

        @(posedge clk);
        #1;
        obs_valid  = bus.out_valid;
        obs_ch     = bus.out_ch;
        obs_data   = bus.out_data;
        obs_primed = bus.out_primed;

        check("out_valid", obs_valid, exp_v);
        if (obs_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_ch", obs_ch, e.ch);
                check("out_data", obs_data, e.data);
                check("out_primed", obs_primed, e.primed);
            end
        end else begin
            if (exp_v) sb.delete();
            check("hold_ch", obs_ch, last_ch);
            check("hold_data", obs_data, last_data);
            check("hold_primed", obs_primed, last_primed);
        end
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic send(input int ch, input int unsigned d);
        step(1'b1, ch, d, 1'b0, 1'b0);
    endtask

    int unsigned t1_in   [5] = '{100, 200, 300, 400, 500};
    int unsigned t1_out  [5] = '{25, 75, 150, 250, 350};
    int unsigned t1_prim [5] = '{0, 0, 0, 1, 1};
    int unsigned t2_ch0  [4] = '{250, 500, 750, 1000};
    int unsigned t2_ch1  [4] = '{1, 2, 3, 4};
`ifdef MAF_ROUND_EN
    int unsigned t3_out  [6] = '{16'h4000, 16'h8000, 16'hBFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    int unsigned t5_out      = 1;
`else
    int unsigned t3_out  [6] = '{16'h3FFF, 16'h7FFF, 16'hBFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    int unsigned t5_out      = 0;
`endif

    initial begin
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;

        // Reset state.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("rst_valid", obs_valid, 0);
        check("rst_data", obs_data, 0);

        // 1. ramp on ch0, including priming.
        for (int i = 0; i < 5; i++) begin
            send(0, t1_in[i]);
            check("t1_data", obs_data, t1_out[i]);
            check("t1_primed", obs_primed, t1_prim[i]);
        end
        idle();

        // 2. interleaved ch0/ch1 from fresh state.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(0, 1000);
            check("t2_ch0", obs_data, t2_ch0[i]);
            send(1, 4);
            check("t2_ch1", obs_data, t2_ch1[i]);
        end

        // 3. full-scale samples on ch2; no wrap.
        for (int i = 0; i < 6; i++) begin
            send(2, 16'hFFFF);
            check("t3_data", obs_data, t3_out[i]);
        end
        idle();

        // 4. clear wins over a simultaneous sample.
        for (int i = 0; i < 4; i++) send(0, 400);
        check("t4_primed_before", obs_primed, 1);
        step(1'b1, 0, 999, 1'b1, 1'b0);
        check("t4_clear_valid", obs_valid, 0);
        send(0, 400);
        check("t4_after_data", obs_data, 100);
        check("t4_after_primed", obs_primed, 0);

        // 5. small value after reset: floor vs round-half-up.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        send(1, 2);
        check("t5_data", obs_data, t5_out);

        // 6. out-of-range channel is dropped; then mid-stream reset.
        send(0, 40);
        step(1'b1, 3, 777, 1'b0, 1'b0);
        check("t6_bad_ch_valid", obs_valid, 0);
        send(2, 8);
        send(0, 60);
        send(1, 6);
        for (int i = 0; i < 6; i++) send($urandom_range(0, 2), $urandom_range(0, 16'hFFFF));
        send(0, 50);
        step(1'b1, 0, 70, 1'b0, 1'b1);
        check("t6_rst_data", obs_data, 0);
        check("t6_rst_primed", obs_primed, 0);
        send(0, 80);
        check("t6_first_after_rst", obs_data, 20);
        send(0, 80);
        send(0, 80);
        send(0, 80);
        check("t6_primed_again", obs_primed, 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
